// File: rtl/tdc_readout_arbiter_if.sv
// rtl/tdc_readout_arbiter_if.sv - source/sink bundle for the TDC readout arbiter
// Purpose: groups the per-source FIFO taps, the merged sink FIFO port and the
//          grant status of tdc_readout_arbiter into one interface.
// Signals:
//   SRC_EN[NUM_SRC]       per-source arbitration enable
//   SRC_EMPTY[NUM_SRC]    source FIFO empty flags (first-word-fall-through)
//   SRC_DATA[32*NUM_SRC]  source FIFO heads, source i at [32i+31:32i]
//   SRC_READ[NUM_SRC]     one-hot pop strobe to the sources
//   FIFO_READ             sink pop request
//   FIFO_EMPTY            merged buffer holds no word
//   FIFO_DATA[32]         merged buffer head word
//   FIFO_SRC[4]           source index of the head word
//   GRANT_VALID           a source currently holds the grant
//   GRANT_IDX[4]          currently or last granted source
// Modports: master = arbiter side, slave = sources/sink side.
interface tdc_readout_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]    SRC_EN;
  logic [NUM_SRC-1:0]    SRC_EMPTY;
  logic [32*NUM_SRC-1:0] SRC_DATA;
  logic [NUM_SRC-1:0]    SRC_READ;
  logic                  FIFO_READ;
  logic                  FIFO_EMPTY;
  logic [31:0]           FIFO_DATA;
  logic [3:0]            FIFO_SRC;
  logic                  GRANT_VALID;
  logic [3:0]            GRANT_IDX;

  modport master (
    input  SRC_EN, SRC_EMPTY, SRC_DATA, FIFO_READ,
    output SRC_READ, FIFO_EMPTY, FIFO_DATA, FIFO_SRC, GRANT_VALID, GRANT_IDX
  );

  modport slave (
    output SRC_EN, SRC_EMPTY, SRC_DATA, FIFO_READ,
    input  SRC_READ, FIFO_EMPTY, FIFO_DATA, FIFO_SRC, GRANT_VALID, GRANT_IDX
  );
endinterface

// File: rtl/tdc_readout_arbiter.sv
// rtl/tdc_readout_arbiter.sv - round-robin burst merger of TDC readout FIFOs
// Purpose: pops up to MAX_BURST words per grant from one of NUM_SRC source
//          FIFOs and merges them into a 2-entry first-word-fall-through
//          buffer tagged with the source index.
// Ports:
//   BUS_CLK  clock for all logic
//   BUS_RST  asynchronous active-high reset
//   bus      tdc_readout_arbiter_if.master (source taps, sink port, grant status)
module tdc_readout_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16
) (
  input logic                     BUS_CLK,
  input logic                     BUS_RST,
  tdc_readout_arbiter_if.master   bus
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t      r_state;
  logic [3:0]  r_grant_idx;
  logic [7:0]  r_burst_cnt;
  logic [35:0] r_buf [2];
  logic [1:0]  r_cnt;

  logic [15:0] w_req;
  logic        w_any_req;
  logic        w_cur_req;
  logic        w_pop;
  logic        w_rd;
  logic [3:0]  w_next_idx;
  logic [31:0] w_sel_data;
  logic [35:0] w_wr_word;

  // Widened to 16 bits so a 4-bit grant index can select any request bit.
  always_comb begin
    w_req = '0;
    w_req[NUM_SRC-1:0] = bus.SRC_EN & ~bus.SRC_EMPTY;
  end

  assign w_any_req = |w_req;
  assign w_cur_req = w_req[r_grant_idx];
  // A full buffer can still take a word when the sink pops in the same cycle.
  assign w_pop     = (r_state == S_BURST) && w_cur_req && ((r_cnt != 2'd2) || bus.FIFO_READ);
  assign w_rd      = bus.FIFO_READ && (r_cnt != 2'd0);

  function automatic logic [3:0] rr_idx(input logic [3:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return s[3:0];
  endfunction

  // Scan downward so the nearest requester after the last grant overwrites last.
  always_comb begin
    w_next_idx = r_grant_idx;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (w_req[rr_idx(r_grant_idx, k)]) w_next_idx = rr_idx(r_grant_idx, k);
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_idx == 4'(i)) w_sel_data = bus.SRC_DATA[32*i +: 32];
    end
  end

  assign w_wr_word = {r_grant_idx, w_sel_data};

  always_comb begin
    bus.SRC_READ = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.SRC_READ[i] = w_pop && (r_grant_idx == 4'(i));
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state     <= S_IDLE;
      r_grant_idx <= 4'(NUM_SRC - 1);
      r_burst_cnt <= '0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_idx <= w_next_idx;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (!w_cur_req) begin
            r_state <= S_IDLE;
          end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            if (r_burst_cnt == 8'(MAX_BURST - 1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Entry 0 is always the head; a write lands behind whatever survives the read.
      case ({w_pop, w_rd})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf[0] <= w_wr_word;
          else               r_buf[1] <= w_wr_word;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf[0] <= r_buf[1];
          r_cnt    <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf[0] <= w_wr_word;
          end else begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= w_wr_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.FIFO_EMPTY  = (r_cnt == 2'd0);
  assign bus.FIFO_DATA   = r_buf[0][31:0];
  assign bus.FIFO_SRC    = r_buf[0][35:32];
  assign bus.GRANT_VALID = (r_state == S_BURST);
  assign bus.GRANT_IDX   = r_grant_idx;

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// tb/tb_tdc_readout_arbiter.sv - directed self-checking bench for tdc_readout_arbiter
module tb_tdc_readout_arbiter;
  localparam int NS = 4;
  localparam int MB = 16;

  logic BUS_CLK = 1'b0;
  logic BUS_RST;

  tdc_readout_arbiter_if #(.NUM_SRC(NS)) bus();

  tdc_readout_arbiter #(.NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .bus     (bus.master)
  );

  initial forever #5 BUS_CLK = ~BUS_CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] q [NS][$];
  logic [35:0] out_q[$];
  int          pop_src[$];
  int          pop_cyc[$];
  int          pops [NS];
  int          run_src[$];
  int          run_len[$];
  int          run_gap[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      bus.SRC_EMPTY[i] = (q[i].size() == 0);
      bus.SRC_DATA[32*i +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
    end
  endtask

  // Source FIFO and sink model: decisions captured at negedge apply at the next posedge.
  task automatic tick();
    logic [NS-1:0] rd;
    logic          sr;
    logic [35:0]   w;
    logic [31:0]   dropped;
    @(negedge BUS_CLK);
    rd = bus.SRC_READ;
    sr = bus.FIFO_READ && !bus.FIFO_EMPTY;
    w  = {bus.FIFO_SRC, bus.FIFO_DATA};
    @(posedge BUS_CLK);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (rd[i]) begin
        if (q[i].size() > 0) dropped = q[i].pop_front();
        pop_src.push_back(i);
        pop_cyc.push_back(cyc);
        pops[i]++;
      end
    end
    if (sr) out_q.push_back(w);
    drive_src();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    out_q.delete();
    pop_src.delete();
    pop_cyc.delete();
    for (int i = 0; i < NS; i++) pops[i] = 0;
  endtask

  task automatic load(input int s, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) q[s].push_back(base + 32'(k));
    drive_src();
  endtask

  task automatic calc_runs();
    run_src.delete();
    run_len.delete();
    run_gap.delete();
    for (int k = 0; k < pop_src.size(); k++) begin
      if (k == 0 || pop_src[k] != pop_src[k-1]) begin
        run_src.push_back(pop_src[k]);
        run_len.push_back(1);
        run_gap.push_back(k == 0 ? 0 : pop_cyc[k] - pop_cyc[k-1]);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
  endtask

  // Per-source order check: words of source s must be base(s)+0,1,2,...
  function automatic int order_errs(input logic [31:0] b0, input logic [31:0] b1,
                                    input logic [31:0] b2, input logic [31:0] b3);
    int n [NS];
    int e;
    logic [31:0] base;
    logic [3:0]  s;
    e = 0;
    for (int i = 0; i < NS; i++) n[i] = 0;
    for (int k = 0; k < out_q.size(); k++) begin
      s = out_q[k][35:32];
      case (s)
        4'd0: base = b0;
        4'd1: base = b1;
        4'd2: base = b2;
        default: base = b3;
      endcase
      if (s >= 4'(NS)) e++;
      else begin
        if (out_q[k][31:0] != base + 32'(n[s])) e++;
        n[s]++;
      end
    end
    return e;
  endfunction

  function automatic int rget(input int which, input int k);
    if (which == 0) return (run_src.size() > k) ? run_src[k] : -1;
    if (which == 1) return (run_len.size() > k) ? run_len[k] : -1;
    return (run_gap.size() > k) ? run_gap[k] : -1;
  endfunction

  function automatic logic [35:0] oget(input int k);
    return (out_q.size() > k) ? out_q[k] : 36'hF_FFFF_FFFF;
  endfunction

  int exp_src1 [6] = '{1, 3, 1, 3, 1, 3};
  int exp_len1 [6] = '{16, 16, 16, 16, 8, 8};
  int exp_gap1 [6] = '{0, 2, 2, 2, 2, 3};
  int exp_src6 [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NS; i++) pops[i] = 0;
    BUS_RST       = 1'b1;
    bus.SRC_EN    = '0;
    bus.FIFO_READ = 1'b0;
    drive_src();
    ticks(2);

    // reset state
    chk("rst_empty", bus.FIFO_EMPTY, 1);
    chk("rst_src_read", bus.SRC_READ, 0);
    chk("rst_data", bus.FIFO_DATA, 0);
    chk("rst_fsrc", bus.FIFO_SRC, 0);
    chk("rst_gvalid", bus.GRANT_VALID, 0);
    chk("rst_gidx", bus.GRANT_IDX, NS - 1);
    BUS_RST = 1'b0;
    ticks(1);

    // single source, 3 words, sink always reading
    bus.SRC_EN    = '1;
    bus.FIFO_READ = 1'b1;
    load(0, 32'hA000_0001, 3);
    tick();
    chk("t1_read_first", bus.SRC_READ, 4'b0001);
    chk("t1_gvalid", bus.GRANT_VALID, 1);
    chk("t1_gidx", bus.GRANT_IDX, 0);
    chk("t1_empty_before", bus.FIFO_EMPTY, 1);
    tick();
    chk("t1_head_data", bus.FIFO_DATA, 32'hA000_0001);
    chk("t1_head_src", bus.FIFO_SRC, 0);
    chk("t1_head_nonempty", bus.FIFO_EMPTY, 0);
    ticks(5);
    chk("t1_pops", pops[0], 3);
    chk("t1_out_n", out_q.size(), 3);
    chk("t1_w0", oget(0), {4'd0, 32'hA000_0001});
    chk("t1_w1", oget(1), {4'd0, 32'hA000_0002});
    chk("t1_w2", oget(2), {4'd0, 32'hA000_0003});
    chk("t1_empty_after", bus.FIFO_EMPTY, 1);
    chk("t1_idle", bus.GRANT_VALID, 0);

    // sources 1 and 3, 40 words each
    clear_logs();
    load(1, 32'h1000_0000, 40);
    load(3, 32'h3000_0000, 40);
    for (int k = 0; k < 250 && out_q.size() < 80; k++) tick();
    ticks(3);
    calc_runs();
    chk("t2_out_n", out_q.size(), 80);
    chk("t2_pops1", pops[1], 40);
    chk("t2_pops3", pops[3], 40);
    chk("t2_order", order_errs(32'h0, 32'h1000_0000, 32'h0, 32'h3000_0000), 0);
    chk("t2_nruns", run_src.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_run%0d_src", k), rget(0, k), exp_src1[k]);
      chk($sformatf("t2_run%0d_len", k), rget(1, k), exp_len1[k]);
      if (k > 0) chk($sformatf("t2_run%0d_gap", k), rget(2, k), exp_gap1[k]);
    end

    // sink stalled, source 2 holds 5 words
    clear_logs();
    bus.FIFO_READ = 1'b0;
    load(2, 32'h2000_0000, 5);
    ticks(6);
    chk("t3_pops_stall", pops[2], 2);
    chk("t3_read_stall", bus.SRC_READ, 0);
    chk("t3_gvalid", bus.GRANT_VALID, 1);
    chk("t3_gidx", bus.GRANT_IDX, 2);
    chk("t3_head", bus.FIFO_DATA, 32'h2000_0000);
    bus.FIFO_READ = 1'b1;
    ticks(10);
    chk("t3_out_n", out_q.size(), 5);
    chk("t3_pops", pops[2], 5);
    chk("t3_order", order_errs(32'h0, 32'h0, 32'h2000_0000, 32'h0), 0);
    chk("t3_w4", oget(4), {4'd2, 32'h2000_0004});

    // SRC_EN[0] dropped after the 4th pop, source 1 pending
    clear_logs();
    load(0, 32'h4000_0000, 10);
    load(1, 32'h5000_0000, 2);
    for (int k = 0; k < 20 && pops[0] < 4; k++) tick();
    bus.SRC_EN[0] = 1'b0;
    #1;
    chk("t4_no_pop", bus.SRC_READ, 0);
    chk("t4_still_burst", bus.GRANT_VALID, 1);
    tick();
    chk("t4_idle", bus.GRANT_VALID, 0);
    tick();
    chk("t4_regrant_valid", bus.GRANT_VALID, 1);
    chk("t4_regrant_idx", bus.GRANT_IDX, 1);
    ticks(8);
    chk("t4_pops0", pops[0], 4);
    chk("t4_pops1", pops[1], 2);
    chk("t4_out_n", out_q.size(), 6);
    chk("t4_w3", oget(3), {4'd0, 32'h4000_0003});
    chk("t4_w4", oget(4), {4'd1, 32'h5000_0000});
    q[0].delete();
    bus.SRC_EN = '1;
    drive_src();

    // reset while the buffer holds 2 words mid-burst
    clear_logs();
    bus.FIFO_READ = 1'b0;
    load(2, 32'h6000_0000, 5);
    ticks(4);
    chk("t5_full_nonempty", bus.FIFO_EMPTY, 0);
    chk("t5_gidx", bus.GRANT_IDX, 2);
    chk("t5_pops", pops[2], 2);
    BUS_RST = 1'b1;
    #1;
    chk("t5_rst_empty", bus.FIFO_EMPTY, 1);
    chk("t5_rst_read", bus.SRC_READ, 0);
    chk("t5_rst_gidx", bus.GRANT_IDX, NS - 1);
    chk("t5_rst_gvalid", bus.GRANT_VALID, 0);
    load(0, 32'h7000_0000, 2);
    bus.FIFO_READ = 1'b1;
    tick();
    chk("t5_rst_hold_read", bus.SRC_READ, 0);
    chk("t5_rst_hold_pops", pops[2], 2);
    clear_logs();
    BUS_RST = 1'b0;
    ticks(15);
    chk("t5_first_src", (pop_src.size() > 0) ? pop_src[0] : -1, 0);
    chk("t5_w0", oget(0), {4'd0, 32'h7000_0000});
    chk("t5_out_n", out_q.size(), 5);
    chk("t5_w2", oget(2), {4'd2, 32'h6000_0002});

    // all sources requesting right after reset, round-robin wrap
    BUS_RST = 1'b1;
    tick();
    for (int s = 0; s < NS; s++) begin
      q[s].delete();
      load(s, 32'h8000_0000 + 32'(s) * 32'h0100_0000, 17);
    end
    clear_logs();
    BUS_RST = 1'b0;
    for (int k = 0; k < 200 && out_q.size() < 68; k++) tick();
    ticks(3);
    calc_runs();
    chk("t6_out_n", out_q.size(), 68);
    chk("t6_nruns", run_src.size(), 8);
    chk("t6_run0_len", rget(1, 0), 16);
    chk("t6_run4_len", rget(1, 4), 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6_run%0d_src", k), rget(0, k), exp_src6[k]);
    end
    chk("t6_order", order_errs(32'h8000_0000, 32'h8100_0000, 32'h8200_0000, 32'h8300_0000), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_readout_arbiter.md
Name: tdc_readout_arbiter

Overview:
Merges the 32-bit readout FIFOs of up to 16 TDC cores into a single FIFO-style stream for the readout/SiTCP path. Source selection is round-robin with a bounded burst length per grant, so one busy TDC cannot starve the others. A 2-entry registered output buffer keeps the sink interface first-word-fall-through. A parallel source-index output identifies where each word came from. Runs entirely in the BUS_CLK domain, downstream of each core's BUS_CLK-side FIFO.

Parameters:
NUM_SRC, 4, number of source FIFOs (1..16).
MAX_BURST, 16, maximum words popped from one source per grant (1..255).

Ports:
BUS_CLK  in  1  clock for all logic.
BUS_RST  in  1  asynchronous, active-high reset.
SRC_EN  in  NUM_SRC  per-source arbitration enable.
SRC_EMPTY  in  NUM_SRC  source FIFO empty flags, first-word-fall-through.
SRC_DATA  in  32*NUM_SRC  source FIFO data; source i occupies bits [32i+31:32i]; valid while SRC_EMPTY[i]=0.
SRC_READ  out  NUM_SRC  one-hot pop strobe to the source FIFOs.
FIFO_READ  in  1  sink pop request.
FIFO_EMPTY  out  1  high when the output buffer holds no word.
FIFO_DATA  out  32  head word of the output buffer.
FIFO_SRC  out  4  source index of the head word.
GRANT_VALID  out  1  high while in the BURST state.
GRANT_IDX  out  4  currently or last granted source.

Behaviour:
- Reset values: SRC_READ=0, FIFO_EMPTY=1, FIFO_DATA=0, FIFO_SRC=0, GRANT_VALID=0, GRANT_IDX=NUM_SRC-1, so that source 0 wins first. Burst count=0, buffer count=0, state=IDLE.
- Request vector: req[i] = SRC_EN[i] & ~SRC_EMPTY[i].
- State machine, two states: IDLE and BURST.
  - IDLE: if req is nonzero, pick the first set bit scanning upward from GRANT_IDX+1 modulo NUM_SRC. Register that index as GRANT_IDX, clear the burst count, and go to BURST. Otherwise stay in IDLE.
  - BURST: pop = req[GRANT_IDX] & (buffer count<2 | FIFO_READ).
  - SRC_READ[GRANT_IDX] = pop. This is combinational and never asserted in IDLE.
  - Each pop increments the burst count.
  - BURST goes to IDLE when any of these holds: !req[GRANT_IDX]; or pop with burst count=MAX_BURST-1.
  - A stall from a full buffer holds BURST without advancing the count.
- Switch cost: exactly one IDLE cycle between grants. Worst-case grant latency for a requester is (NUM_SRC-1)*(MAX_BURST+1) cycles while the sink drains continuously.
- Output buffer: 2-entry register FIFO storing {src_idx[3:0], data[31:0]}.
  - The popped source word is written in the same BUS_CLK edge as the pop.
  - Head appears on FIFO_DATA/FIFO_SRC one cycle after the pop.
  - FIFO_READ while FIFO_EMPTY=1 is ignored.
  - Simultaneous write and read with count=2 keeps count=2, preserves order, and loses no data.
- Ordering: words from one source always leave in source order. No reordering within a burst.
- SRC_EN[g] deasserted mid-burst: no pop that cycle; state goes to IDLE next edge. Words already in the buffer are still delivered.
- Source empties mid-burst: release immediately. The source regains a grant only after its round-robin turn.
- NUM_SRC=1: the grant alternates IDLE/BURST on that source, with a one-cycle bubble every MAX_BURST words.
- BUS_RST asserted mid-operation: all state returns to reset values asynchronously and buffered words are discarded. No SRC_READ is issued while reset is high.

Test Plan:
- Single source 0 holding 3 words (0xA0000001..3), NUM_SRC=4, sink always reading -> SRC_READ[0] pulses 3 cycles starting 1 cycle after SRC_EMPTY falls. FIFO_DATA shows the words in order with FIFO_SRC=0, then FIFO_EMPTY=1.
- Sources 1 and 3 each holding 40 words, MAX_BURST=16, sink always reading -> grant sequence 1,3,1,3,1,3 with bursts of 16,16,16,16,8,8 and one bubble between grants. 80 words out, none lost or duplicated.
- Sink holds FIFO_READ=0 with source 2 holding 5 words -> exactly 2 pops, then SRC_READ=0 and GRANT_VALID stays 1. Raising FIFO_READ drains the remaining 3 words in order.
- Source 0 has 10 words and SRC_EN[0] is cleared after the 4th pop -> no further pops. State goes to IDLE, 4 words are delivered, and source 1 (pending) is granted next.
- BUS_RST pulsed while the buffer holds 2 words mid-burst -> FIFO_EMPTY=1 and SRC_READ=0 immediately, GRANT_IDX=NUM_SRC-1. After release, arbitration restarts at source 0.
- All sources requesting simultaneously after reset -> first grant goes to source 0, then 1, 2, 3, 0 (round-robin wrap verified).
